// File: rtl/vigenere_stream_engine_if.sv
// ---------------------------------------------------------------------------
// vigenere_stream_engine_if
// Streaming bus for vigenere_stream_engine.
//   key stream : key_valid/key_data/key_last -> key_ready
//   in stream  : in_valid/in_data/in_last/mode -> in_ready
//   out stream : out_valid/out_data/out_last  <- out_ready
//   status     : key_len (loaded key length), key_err (sticky bad key byte),
//                busy (engine not idle)
// Modports: slave = engine side, master = producer/consumer side.
// KEY_MAX must match the engine's KEY_MAX so key_len widths agree.
// ---------------------------------------------------------------------------
interface vigenere_stream_engine_if #(
  parameter int KEY_MAX = 16
);
  localparam int LEN_W = $clog2(KEY_MAX + 1);

  logic             mode;
  logic             key_valid;
  logic [7:0]       key_data;
  logic             key_last;
  logic             key_ready;
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_last;
  logic             in_ready;
  logic             out_valid;
  logic [7:0]       out_data;
  logic             out_last;
  logic             out_ready;
  logic [LEN_W-1:0] key_len;
  logic             key_err;
  logic             busy;

  modport slave (
    input  mode, key_valid, key_data, key_last, in_valid, in_data, in_last, out_ready,
    output key_ready, in_ready, out_valid, out_data, out_last, key_len, key_err, busy
  );

  modport master (
    output mode, key_valid, key_data, key_last, in_valid, in_data, in_last, out_ready,
    input  key_ready, in_ready, out_valid, out_data, out_last, key_len, key_err, busy
  );
endinterface

// File: rtl/vigenere_stream_engine.sv
// ---------------------------------------------------------------------------
// vigenere_stream_engine
// Byte-serial Vigenere encrypt/decrypt engine with a runtime-loaded key and a
// small output FIFO.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - vigenere_stream_engine_if.slave (key / in / out streams + status)
// Parameters:
//   KEY_MAX    - maximum key length in bytes (>=1)
//   FIFO_DEPTH - output FIFO entries (power of 2, >=2)
// Optional feature macro: VIGENERE_PRESERVE_CASE_EN
//   defined   -> lowercase input letters produce lowercase output
//   undefined -> all letters are emitted uppercase
// ---------------------------------------------------------------------------
module vigenere_stream_engine #(
  parameter int KEY_MAX    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input logic                     clk,
  input logic                     rst,
  vigenere_stream_engine_if.slave bus
);
  localparam int LEN_W = $clog2(KEY_MAX + 1);
  localparam int IDX_W = (KEY_MAX > 1) ? $clog2(KEY_MAX) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0] ki_q, ki_d;
  logic [LEN_W-1:0] key_len_q, key_len_d;
  logic             key_err_q, key_err_d;
  logic             key_ready_q, key_ready_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Key stored as pre-computed shift amounts (0..25).
  logic [4:0] key_mem [KEY_MAX];
  // FIFO entry: {last, data}
  logic [8:0] fifo_mem [FIFO_DEPTH];

  // ---------------- key byte decode ----------------
  logic       key_lower, key_letter, key_we;
  logic [7:0] key_up;
  logic [4:0] key_shift;

  always_comb begin
    key_lower  = bus.key_data inside {[8'h61:8'h7A]};
    key_up     = key_lower ? (bus.key_data - 8'd32) : bus.key_data;
    key_letter = key_up inside {[8'h41:8'h5A]};
    // 'A'..'Z' have low five bits 1..26, so subtracting 1 yields the shift.
    key_shift  = key_letter ? (key_up[4:0] - 5'd1) : 5'd0;
    key_we     = key_ready_q && bus.key_valid;
  end

  // ---------------- message byte transform ----------------
  logic       in_lower, in_letter;
  logic [7:0] in_up, xform;
  logic [5:0] p_val, k_val, sum, res;

  always_comb begin
    in_lower  = bus.in_data inside {[8'h61:8'h7A]};
    in_up     = in_lower ? (bus.in_data - 8'd32) : bus.in_data;
    in_letter = in_up inside {[8'h41:8'h5A]};
    p_val     = in_up[5:0] - 6'd1;
    k_val     = {1'b0, key_mem[ki_q]};
    // Both forms stay within 0..51, so a single conditional subtract is a full mod 26.
    sum       = bus.mode ? (p_val + 6'd26 - k_val) : (p_val + k_val);
    res       = (sum >= 6'd26) ? (sum - 6'd26) : sum;
    xform     = bus.in_data;
    if (in_letter) begin
`ifdef VIGENERE_PRESERVE_CASE_EN
      xform = (in_lower ? 8'h61 : 8'h41) + {2'b00, res};
`else
      xform = 8'h41 + {2'b00, res};
`endif
    end
  end

  // ---------------- control ----------------
  logic push, pop;

  always_comb begin
    state_d   = state_q;
    wr_idx_d  = wr_idx_q;
    ki_d      = ki_q;
    key_len_d = key_len_q;
    key_err_d = key_err_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;

    // in_ready_q is only ever high in RUN, so this is the accept condition.
    push = bus.in_valid && in_ready_q;
    pop  = (count_q != '0) && bus.out_ready;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    unique case (state_q)
      S_IDLE: begin
        if (bus.key_valid) begin
          // A load starts at wr_idx 0; that first byte resets the error flag.
          key_err_d = ((wr_idx_q == '0) ? 1'b0 : key_err_q) | ~key_letter;
          if (bus.key_last || (wr_idx_q == IDX_W'(KEY_MAX - 1))) begin
            key_len_d = LEN_W'(wr_idx_q) + LEN_W'(1);
            wr_idx_d  = '0;
            state_d   = S_RUN;
          end else begin
            wr_idx_d = wr_idx_q + 1'b1;
          end
        end else if (bus.in_valid && (key_len_q != '0)) begin
          // Reuse the stored key; the byte is taken once RUN raises in_ready.
          wr_idx_d = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (push) begin
          if (in_letter) begin
            ki_d = (LEN_W'(ki_q) == key_len_q - LEN_W'(1)) ? '0 : ki_q + 1'b1;
          end
          if (bus.in_last) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // No pushes here, so count_d==0 means the final byte leaves this edge.
        if (count_d == '0) begin
          ki_d    = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    key_ready_d = (state_d == S_IDLE);
    in_ready_d  = (state_d == S_RUN) && (count_d < CNT_W'(FIFO_DEPTH));
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_idx_q    <= '0;
      ki_q        <= '0;
      key_len_q   <= '0;
      key_err_q   <= 1'b0;
      key_ready_q <= 1'b1;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      wr_idx_q    <= wr_idx_d;
      ki_q        <= ki_d;
      key_len_q   <= key_len_d;
      key_err_q   <= key_err_d;
      key_ready_q <= key_ready_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
    end
  end

  // Storage arrays carry no reset; key_len and count gate their contents.
  always_ff @(posedge clk) begin
    if (key_we) key_mem[wr_idx_q] <= key_shift;
    if (push)   fifo_mem[wr_ptr_q] <= {bus.in_last, xform};
  end

  assign bus.key_ready = key_ready_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (count_q != '0);
  assign bus.out_data  = (count_q != '0) ? fifo_mem[rd_ptr_q][7:0] : 8'h00;
  assign bus.out_last  = (count_q != '0) ? fifo_mem[rd_ptr_q][8] : 1'b0;
  assign bus.key_len   = key_len_q;
  assign bus.key_err   = key_err_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_vigenere_stream_engine.sv
// ---------------------------------------------------------------------------
// tb_vigenere_stream_engine
// Self-checking bench: drives key/message streams with random gaps and
// random sink back-pressure, and compares the output stream with a
// character-level Vigenere reference model.
// Optional feature macro: VIGENERE_PRESERVE_CASE_EN
// ---------------------------------------------------------------------------
module tb_vigenere_stream_engine;
  localparam int KEY_MAX    = 16;
  localparam int FIFO_DEPTH = 4;
`ifdef VIGENERE_PRESERVE_CASE_EN
  localparam bit PRESERVE = 1'b1;
`else
  localparam bit PRESERVE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  vigenere_stream_engine_if #(.KEY_MAX(KEY_MAX)) vif ();

  vigenere_stream_engine #(.KEY_MAX(KEY_MAX), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (vif)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  int         sent_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_data[$];
  logic       rx_last[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: classic Vigenere over A..Z with plain modular arithmetic.
  function automatic void build_expected(input string key, input string msg, input bit md);
    int ki;
    ki = 0;
    exp_q.delete();
    for (int i = 0; i < msg.len(); i++) begin
      int c, up, kc, k, r;
      bit lower;
      c     = int'(msg[i]);
      lower = (c >= 97 && c <= 122);
      up    = lower ? c - 32 : c;
      if (up >= 65 && up <= 90) begin
        kc = int'(key[ki]);
        if (kc >= 97 && kc <= 122) kc = kc - 32;
        k = (kc >= 65 && kc <= 90) ? kc - 65 : 0;
        r = md ? (up - 65 - k + 26) % 26 : (up - 65 + k) % 26;
        exp_q.push_back(8'((PRESERVE && lower) ? 97 + r : 65 + r));
        ki = (ki + 1) % key.len();
      end else begin
        exp_q.push_back(8'(c));
      end
    end
  endfunction

  function automatic string rand_text(input int n, input bit key_mode);
    string s;
    string punct;
    s     = "";
    punct = " !.,3_9";
    for (int i = 0; i < n; i++) begin
      int sel;
      int c;
      sel = int'($urandom_range(0, 9));
      if (sel < 4)      c = 65 + int'($urandom_range(0, 25));
      else if (sel < 8) c = 97 + int'($urandom_range(0, 25));
      else if (key_mode && sel == 8) c = 65 + int'($urandom_range(0, 25));
      else              c = int'(punct[int'($urandom_range(0, 6))]);
      s = $sformatf("%s%c", s, c[7:0]);
    end
    return s;
  endfunction

  task automatic load_key(input string k, output bit err_first);
    int guard;
    int i;
    guard     = 0;
    i         = 0;
    err_first = 1'b0;
    @(negedge clk);
    while (i < k.len() && guard < 200) begin
      bit rdy;
      vif.key_valid = 1'b1;
      vif.key_data  = k[i];
      vif.key_last  = (i == k.len() - 1);
      rdy           = vif.key_ready;
      @(negedge clk);
      if (rdy) begin
        if (i == 0) err_first = vif.key_err;
        i++;
      end
      guard++;
    end
    vif.key_valid = 1'b0;
    vif.key_last  = 1'b0;
    check_eq("key_load_count", i, k.len());
  endtask

  task automatic send_msg(input string m, input bit md, input bit with_last, input bit gaps);
    int guard;
    guard    = 0;
    sent_cnt = 0;
    @(negedge clk);
    while (sent_cnt < m.len() && guard < 3000) begin
      bit rdy;
      if (gaps && $urandom_range(0, 3) == 0) begin
        vif.in_valid = 1'b0;
        rdy          = 1'b0;
      end else begin
        vif.in_valid = 1'b1;
        vif.in_data  = m[sent_cnt];
        vif.in_last  = with_last && (sent_cnt == m.len() - 1);
        vif.mode     = md;
        rdy          = vif.in_ready;
      end
      @(negedge clk);
      if (rdy) sent_cnt++;
      guard++;
    end
    vif.in_valid = 1'b0;
    vif.in_last  = 1'b0;
    check_eq("tx_count", sent_cnt, m.len());
  endtask

  task automatic collect(input bit random_ready);
    int guard;
    bit done;
    guard = 0;
    done  = 1'b0;
    rx_data.delete();
    rx_last.delete();
    while (!done && guard < 3000) begin
      @(negedge clk);
      vif.out_ready = random_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (vif.out_valid && vif.out_ready) begin
        rx_data.push_back(vif.out_data);
        rx_last.push_back(vif.out_last);
        if (vif.out_last) done = 1'b1;
      end
      guard++;
    end
    @(negedge clk);
    vif.out_ready = 1'b0;
    check_eq("rx_last_seen", done, 1'b1);
  endtask

  task automatic compare_rx(input string tag);
    check_eq({tag, "_len"}, rx_data.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_data.size(); i++) begin
      $display("%s byte %0d: got '%c' expected '%c' last=%0d", tag, i, rx_data[i], exp_q[i], rx_last[i]);
      check_eq($sformatf("%s_data%0d", tag, i), rx_data[i], exp_q[i]);
      check_eq($sformatf("%s_last%0d", tag, i), rx_last[i], (i == exp_q.size() - 1));
    end
  endtask

  task automatic wait_idle(input string tag);
    int guard;
    guard = 0;
    while (vif.busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check_eq({tag, "_busy"}, vif.busy, 1'b0);
    check_eq({tag, "_key_ready"}, vif.key_ready, 1'b1);
  endtask

  task automatic run_msg(input string tag, input string key, input string msg, input bit md);
    build_expected(key, msg, md);
    fork
      send_msg(msg, md, 1'b1, 1'b1);
      collect(1'b1);
    join
    compare_rx(tag);
    wait_idle(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    string key16;
    string m;
    bit    ef;
    int    acc;
    int    guard;
    logic [7:0] d0;

    vif.mode = 1'b0; vif.key_valid = 1'b0; vif.key_data = 8'h00; vif.key_last = 1'b0;
    vif.in_valid = 1'b0; vif.in_data = 8'h00; vif.in_last = 1'b0; vif.out_ready = 1'b0;

    // Reset values
    rst = 1'b1;
    #12;
    check_eq("rst_key_ready", vif.key_ready, 1'b1);
    check_eq("rst_in_ready", vif.in_ready, 1'b0);
    check_eq("rst_out_valid", vif.out_valid, 1'b0);
    check_eq("rst_key_len", vif.key_len, 0);
    check_eq("rst_key_err", vif.key_err, 1'b0);
    check_eq("rst_busy", vif.busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Key "KEY", encrypt then decrypt with the same stored key
    load_key("KEY", ef);
    check_eq("kkey_len", vif.key_len, 3);
    run_msg("enc_key", "KEY", "HeLlo W", 1'b0);
    run_msg("dec_key", "KEY", "RIJVS U", 1'b1);
    check_eq("reuse_key_len", vif.key_len, 3);

    // Single-letter key, then a non-letter key byte
    load_key("A", ef);
    check_eq("a_key_len", vif.key_len, 1);
    run_msg("key_a", "A", "ZzZ!", 1'b0);
    load_key("3", ef);
    check_eq("digit_key_err", vif.key_err, 1'b1);
    run_msg("key_3", "3", "Ab1", 1'b0);
    check_eq("key_err_sticky", vif.key_err, 1'b1);
    load_key("BC", ef);
    check_eq("key_err_first_clear", ef, 1'b0);
    run_msg("key_bc", "BC", "xyz.Q", 1'b1);

    // Seventeen key bytes offered without key_last: only KEY_MAX taken
    key16 = rand_text(17, 1'b1);
    acc   = 0;
    guard = 0;
    @(negedge clk);
    while (acc < 17 && guard < 40) begin
      bit rdy;
      vif.key_valid = 1'b1;
      vif.key_data  = key16[acc];
      vif.key_last  = 1'b0;
      rdy           = vif.key_ready;
      @(negedge clk);
      guard++;
      if (rdy) acc++;
      else break;
    end
    vif.key_valid = 1'b0;
    check_eq("max_key_accepted", acc, KEY_MAX);
    check_eq("max_key_ready", vif.key_ready, 1'b0);
    check_eq("max_key_len", vif.key_len, KEY_MAX);
    check_eq("max_key_busy", vif.busy, 1'b1);
    key16 = key16.substr(0, KEY_MAX - 1);
    run_msg("key16", key16, rand_text(24, 1'b0), 1'($urandom_range(0, 1)));

    // Back-pressure: sink stalled, six bytes offered into a four-entry FIFO
    m = "FiFo!Z";
    build_expected(key16, m, 1'b0);
    vif.out_ready = 1'b0;
    fork
      send_msg(m, 1'b0, 1'b1, 1'b0);
      begin
        repeat (15) @(negedge clk);
        check_eq("bp_accepted", sent_cnt, FIFO_DEPTH);
        check_eq("bp_in_ready", vif.in_ready, 1'b0);
        check_eq("bp_out_valid", vif.out_valid, 1'b1);
        d0 = vif.out_data;
        check_eq("bp_head", d0, exp_q[0]);
        repeat (3) @(negedge clk);
        check_eq("bp_stable", vif.out_data, d0);
        collect(1'b1);
      end
    join
    compare_rx("bp");
    wait_idle("bp");

    // Randomised keys and messages
    for (int it = 0; it < 6; it++) begin
      string k;
      k = rand_text(int'($urandom_range(1, 8)), 1'b1);
      load_key(k, ef);
      check_eq($sformatf("rnd%0d_key_len", it), vif.key_len, k.len());
      run_msg($sformatf("rnd%0d", it), k, rand_text(int'($urandom_range(1, 20)), 1'b0),
              1'($urandom_range(0, 1)));
    end

    // Asynchronous reset with two bytes sitting in the FIFO
    load_key("QZ", ef);
    vif.out_ready = 1'b0;
    send_msg("AB", 1'b0, 1'b0, 1'b0);
    check_eq("prerst_out_valid", vif.out_valid, 1'b1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_out_valid", vif.out_valid, 1'b0);
    check_eq("arst_key_len", vif.key_len, 0);
    check_eq("arst_key_ready", vif.key_ready, 1'b1);
    check_eq("arst_in_ready", vif.in_ready, 1'b0);
    check_eq("arst_busy", vif.busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Engine fully usable after the reset
    load_key("KEY", ef);
    run_msg("post_rst", "KEY", "HeLlo W", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
